// File: rtl/audio_mix_pkg.sv
`default_nettype none
// audio_mix_pkg: shared types and helpers for the audio_mix_dac mixer.
// Revision 1.0

package audio_mix_pkg;

   typedef enum logic [1:0] {
      MUTE    = 2'd0,
      QUARTER = 2'd1,
      HALF    = 2'd2,
      UNITY   = 2'd3
   } gain_t;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ACCUM   = 2'd1,
      PUBLISH = 2'd2
   } mix_state_t;

   // MUTE maps to 0 here; the caller suppresses the term instead of shifting it out.
   function automatic logic [1:0] gain_shift(gain_t g);
      case (g)
         UNITY:   return 2'd0;
         HALF:    return 2'd1;
         QUARTER: return 2'd2;
         default: return 2'd0;
      endcase
   endfunction

endpackage

`default_nettype wire

// File: rtl/audio_mix_dac_if.sv
`default_nettype none
// audio_mix_dac_if: channel inputs and mixed-sample outputs of audio_mix_dac.
// Revision 1.0

interface audio_mix_dac_if #(
   parameter int CHANNELS = 4,
   parameter int IN_W     = 14,
   parameter int OUT_W    = 16
);
   logic                     ce_sample_i;
   logic [CHANNELS*IN_W-1:0] ch_data_i;
   logic [CHANNELS*2-1:0]    ch_gain_i;
   logic [OUT_W-1:0]         sample_o;
   logic [OUT_W-1:0]         sample_s_o;
   logic                     valid_o;
   logic                     busy_o;
   logic                     overrun_o;
   logic                     pdm_o;

   modport master (
      output ce_sample_i, ch_data_i, ch_gain_i,
      input  sample_o, sample_s_o, valid_o, busy_o, overrun_o, pdm_o
   );

   modport slave (
      input  ce_sample_i, ch_data_i, ch_gain_i,
      output sample_o, sample_s_o, valid_o, busy_o, overrun_o, pdm_o
   );
endinterface

`default_nettype wire

// File: rtl/audio_mix_sd.sv
`default_nettype none
// audio_mix_sd: first-order sigma-delta modulator; ones density = sample / 2^OUT_W.
// Revision 1.0

module audio_mix_sd #(
   parameter int OUT_W = 16
) (
   input  logic             clk,
   input  logic             res_n,
   input  logic [OUT_W-1:0] sample,
   output logic             pdm
);
   logic [OUT_W-1:0] acc;
   logic [OUT_W:0]   sum;

   assign sum = {1'b0, acc} + {1'b0, sample};

   always_ff @(posedge clk or negedge res_n) begin
      if (!res_n) begin
         acc <= '0;
         pdm <= 1'b0;
      end else begin
         acc <= sum[OUT_W-1:0];
         pdm <= sum[OUT_W];
      end
   end
endmodule

`default_nettype wire

// File: rtl/audio_mix_dac.sv
`default_nettype none
// audio_mix_dac: time-multiplexed gain mixer with optional 1-bit DAC (AUDIO_MIX_PDM_EN).
// Revision 1.0

module audio_mix_dac
   import audio_mix_pkg::*;
#(
   parameter int CHANNELS = 4,
   parameter int IN_W     = 14,
   parameter int OUT_W    = 16
) (
   input  logic            clk_i,
   input  logic            res_n_i,
   audio_mix_dac_if.slave  bus
);
   localparam int ACC_W = IN_W + $clog2(CHANNELS);
   localparam int IDX_W = $clog2(CHANNELS);

   mix_state_t       state;
   mix_state_t       state_nxt;
   logic [IDX_W-1:0] idx;
   logic [ACC_W-1:0] acc;
   logic [IN_W-1:0]  snap_data [CHANNELS];
   gain_t            snap_gain [CHANNELS];
   logic [IN_W-1:0]  term;
   logic [OUT_W-1:0] sample;
   logic [OUT_W-1:0] scaled;
   logic             valid;
   logic             overrun;
   logic             busy;
   logic             last;
   logic             pdm;

   assign last = (idx == IDX_W'(CHANNELS - 1));

   always_ff @(posedge clk_i or negedge res_n_i) begin
      if (!res_n_i) state <= IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (bus.ce_sample_i) state_nxt = ACCUM;
         ACCUM:   if (last) state_nxt = PUBLISH;
         PUBLISH: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      busy = (state != IDLE);
   end

   always_comb begin
      term = '0;
      if (snap_gain[idx] != MUTE) term = snap_data[idx] >> gain_shift(snap_gain[idx]);
   end

   always_ff @(posedge clk_i or negedge res_n_i) begin
      if (!res_n_i) begin
         acc     <= '0;
         idx     <= '0;
         sample  <= '0;
         valid   <= 1'b0;
         overrun <= 1'b0;
         for (int k = 0; k < CHANNELS; k++) begin
            snap_data[k] <= '0;
            snap_gain[k] <= MUTE;
         end
      end else begin
         valid <= 1'b0;
         // Strobes outside IDLE are dropped; the flag is sticky until reset.
         if (bus.ce_sample_i && (state != IDLE)) overrun <= 1'b1;
         case (state)
            IDLE: begin
               if (bus.ce_sample_i) begin
                  acc <= '0;
                  idx <= '0;
                  for (int k = 0; k < CHANNELS; k++) begin
                     snap_data[k] <= bus.ch_data_i[k*IN_W +: IN_W];
                     snap_gain[k] <= gain_t'(bus.ch_gain_i[k*2 +: 2]);
                  end
               end
            end
            ACCUM: begin
               acc <= acc + ACC_W'(term);
               if (!last) idx <= idx + 1'b1;
            end
            PUBLISH: begin
               sample <= scaled;
               valid  <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   generate
      if (OUT_W >= ACC_W) begin : g_scale_up
         assign scaled = OUT_W'(acc) << (OUT_W - ACC_W);
      end else begin : g_scale_trunc
         assign scaled = acc[ACC_W-1 -: OUT_W];
      end
   endgenerate

`ifdef AUDIO_MIX_PDM_EN
   audio_mix_sd #(.OUT_W(OUT_W)) u_sd (
      .clk    (clk_i),
      .res_n  (res_n_i),
      .sample (sample),
      .pdm    (pdm)
   );
`else
   assign pdm = 1'b0;
`endif

   assign bus.sample_o   = sample;
   assign bus.sample_s_o = {~sample[OUT_W-1], sample[OUT_W-2:0]};
   assign bus.valid_o    = valid;
   assign bus.busy_o     = busy;
   assign bus.overrun_o  = overrun;
   assign bus.pdm_o      = pdm;
endmodule

`default_nettype wire

// File: tb/tb_audio_mix_dac.sv
`default_nettype none
// tb_audio_mix_dac: randomized self-checking bench against an arithmetic mix model.
// Revision 1.0

module tb_audio_mix_dac;
   localparam int C     = 4;
   localparam int IN_W  = 14;
   localparam int OUT_W = 16;
   localparam int ACC_W = IN_W + $clog2(C);

   logic clk;
   logic res_n;
   int   errors = 0;
   int   checks = 0;

   audio_mix_dac_if #(.CHANNELS(C), .IN_W(IN_W), .OUT_W(OUT_W)) bus ();

   audio_mix_dac #(.CHANNELS(C), .IN_W(IN_W), .OUT_W(OUT_W)) dut (
      .clk_i   (clk),
      .res_n_i (res_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Gain code n (1..3) scales by 2^(n-3); code 0 mutes.
   function automatic logic [OUT_W-1:0] model_mix(input logic [IN_W-1:0] dd [C], input logic [1:0] gg [C]);
      longint unsigned sum = 0;
      for (int k = 0; k < C; k++)
         if (gg[k] != 2'd0) sum += longint'(dd[k]) / (longint'(1) << (3 - int'(gg[k])));
      if (OUT_W >= ACC_W) return OUT_W'(sum * (longint'(1) << (OUT_W - ACC_W)));
      else                return OUT_W'(sum / (longint'(1) << (ACC_W - OUT_W)));
   endfunction

   task automatic drive_inputs(input logic [IN_W-1:0] dd [C], input logic [1:0] gg [C]);
      for (int k = 0; k < C; k++) begin
         bus.ch_data_i[k*IN_W +: IN_W] = dd[k];
         bus.ch_gain_i[k*2 +: 2]       = gg[k];
      end
   endtask

   task automatic randomize_ch(output logic [IN_W-1:0] dd [C], output logic [1:0] gg [C]);
      for (int k = 0; k < C; k++) begin
         dd[k] = IN_W'($urandom);
         gg[k] = 2'($urandom);
      end
   endtask

   // Strobes one mix; lat = clocks from strobe edge to valid (0 on timeout).
   task automatic run_mix(input logic [IN_W-1:0] dd [C], input logic [1:0] gg [C], input bit change,
                          output logic [OUT_W-1:0] s, output int lat, output logic busy_seen);
      @(negedge clk);
      drive_inputs(dd, gg);
      bus.ce_sample_i = 1'b1;
      @(negedge clk);
      bus.ce_sample_i = 1'b0;
      if (change) begin
         bus.ch_data_i = ~bus.ch_data_i;
         bus.ch_gain_i = ~bus.ch_gain_i;
      end
      busy_seen = bus.busy_o;
      lat = 0;
      s   = 'x;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (bus.valid_o) begin
            lat = i;
            s   = bus.sample_o;
            break;
         end
      end
   endtask

   task automatic test_reset();
      res_n = 1'b0;
      bus.ce_sample_i = 1'b0;
      bus.ch_data_i = '0;
      bus.ch_gain_i = '0;
      repeat (2) @(negedge clk);
      checks++; if (bus.sample_o !== 16'h0000) begin errors++; $display("FAIL reset_sample: got %h expected 0000", bus.sample_o); end
      checks++; if (bus.sample_s_o !== 16'h8000) begin errors++; $display("FAIL reset_sample_s: got %h expected 8000", bus.sample_s_o); end
      checks++; if (bus.valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", bus.valid_o); end
      checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy_o); end
      checks++; if (bus.overrun_o !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b expected 0", bus.overrun_o); end
      checks++; if (bus.pdm_o !== 1'b0) begin errors++; $display("FAIL reset_pdm: got %b expected 0", bus.pdm_o); end
      res_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_single_channel();
      logic [IN_W-1:0] dd [C];
      logic [1:0] gg [C];
      logic [OUT_W-1:0] s;
      int lat;
      logic b;
      randomize_ch(dd, gg);
      for (int k = 0; k < C; k++) gg[k] = 2'd0;
      dd[0] = 14'h3FFF;
      gg[0] = 2'd3;
      run_mix(dd, gg, 1'b0, s, lat, b);
      checks++; if (lat !== C + 1) begin errors++; $display("FAIL single_latency: got %0d expected %0d", lat, C + 1); end
      checks++; if (s !== 16'h3FFF) begin errors++; $display("FAIL single_sample: got %h expected 3fff", s); end
      checks++; if (bus.sample_s_o !== 16'hBFFF) begin errors++; $display("FAIL single_sample_s: got %h expected bfff", bus.sample_s_o); end
      checks++; if (b !== 1'b1) begin errors++; $display("FAIL single_busy: got %b expected 1", b); end
      @(negedge clk);
      checks++; if (bus.valid_o !== 1'b0) begin errors++; $display("FAIL single_valid_pulse: got %b expected 0", bus.valid_o); end
      checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL single_busy_after: got %b expected 0", bus.busy_o); end
   endtask

   task automatic test_full_scale();
      logic [IN_W-1:0] dd [C];
      logic [1:0] gg [C];
      logic [OUT_W-1:0] s;
      int lat;
      logic b;
      for (int k = 0; k < C; k++) begin dd[k] = 14'h3FFF; gg[k] = 2'd3; end
      run_mix(dd, gg, 1'b0, s, lat, b);
      checks++; if (s !== 16'hFFFC) begin errors++; $display("FAIL full_scale: got %h expected fffc", s); end
      randomize_ch(dd, gg);
      for (int k = 0; k < C; k++) gg[k] = 2'd0;
      dd[1] = 14'h1000;
      gg[1] = 2'd1;
      run_mix(dd, gg, 1'b0, s, lat, b);
      checks++; if (s !== 16'h0400) begin errors++; $display("FAIL quarter_gain: got %h expected 0400", s); end
      // Held between mixes.
      repeat (5) @(negedge clk);
      checks++; if (bus.sample_o !== 16'h0400) begin errors++; $display("FAIL sample_hold: got %h expected 0400", bus.sample_o); end
   endtask

   task automatic test_random();
      logic [IN_W-1:0] dd [C];
      logic [1:0] gg [C];
      logic [OUT_W-1:0] s, exp_s;
      int lat;
      logic b;
      for (int n = 0; n < 20; n++) begin
         randomize_ch(dd, gg);
         exp_s = model_mix(dd, gg);
         run_mix(dd, gg, 1'b0, s, lat, b);
         checks++; if (lat !== C + 1) begin errors++; $display("FAIL random_latency[%0d]: got %0d expected %0d", n, lat, C + 1); end
         checks++; if (s !== exp_s) begin errors++; $display("FAIL random_sample[%0d]: got %h expected %h", n, s, exp_s); end
         checks++;
         if (bus.sample_s_o !== {~exp_s[OUT_W-1], exp_s[OUT_W-2:0]}) begin
            errors++; $display("FAIL random_sample_s[%0d]: got %h expected %h", n, bus.sample_s_o, {~exp_s[OUT_W-1], exp_s[OUT_W-2:0]});
         end
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end
   endtask

   task automatic test_snapshot();
      logic [IN_W-1:0] dd [C];
      logic [1:0] gg [C];
      logic [OUT_W-1:0] s, exp_s;
      int lat;
      logic b;
      for (int n = 0; n < 4; n++) begin
         randomize_ch(dd, gg);
         gg[n] = 2'd3;
         exp_s = model_mix(dd, gg);
         run_mix(dd, gg, 1'b1, s, lat, b);
         checks++; if (s !== exp_s) begin errors++; $display("FAIL snapshot[%0d]: got %h expected %h", n, s, exp_s); end
      end
   endtask

   task automatic test_overrun();
      logic [IN_W-1:0] da [C], db [C], dc [C];
      logic [1:0] ga [C];
      logic [OUT_W-1:0] s1, s2;
      int vcount, t1, t2;
      logic ov_early;
      randomize_ch(da, ga);
      randomize_ch(db, ga);
      for (int k = 0; k < C; k++) begin dc[k] = ~da[k]; ga[k] = 2'd3; end
      @(negedge clk);
      res_n = 1'b0;
      @(negedge clk);
      res_n = 1'b1;
      vcount = 0; t1 = 0; t2 = 0; ov_early = 1'b0; s1 = '0; s2 = '0;
      for (int c = 0; c < 16; c++) begin
         @(negedge clk);
         if (bus.valid_o) begin
            vcount++;
            if (vcount == 1) begin t1 = c; s1 = bus.sample_o; end
            else begin t2 = c; s2 = bus.sample_o; end
         end
         if (c == 4) ov_early = bus.overrun_o;
         bus.ce_sample_i = (c == 0 || c == 3 || c == 6);
         if (c == 3)      drive_inputs(dc, ga);
         else if (c >= 6) drive_inputs(db, ga);
         else             drive_inputs(da, ga);
      end
      bus.ce_sample_i = 1'b0;
      checks++; if (ov_early !== 1'b1) begin errors++; $display("FAIL overrun_set: got %b expected 1", ov_early); end
      checks++; if (vcount !== 2) begin errors++; $display("FAIL overrun_valid_count: got %0d expected 2", vcount); end
      checks++; if (t1 !== C + 2) begin errors++; $display("FAIL overrun_first_time: got %0d expected %0d", t1, C + 2); end
      checks++; if (s1 !== model_mix(da, ga)) begin errors++; $display("FAIL overrun_first_sample: got %h expected %h", s1, model_mix(da, ga)); end
      checks++; if (t2 !== 2 * C + 4) begin errors++; $display("FAIL overrun_second_time: got %0d expected %0d", t2, 2 * C + 4); end
      checks++; if (s2 !== model_mix(db, ga)) begin errors++; $display("FAIL overrun_second_sample: got %h expected %h", s2, model_mix(db, ga)); end
      checks++; if (bus.overrun_o !== 1'b1) begin errors++; $display("FAIL overrun_sticky: got %b expected 1", bus.overrun_o); end
   endtask

   task automatic test_reset_mid_mix();
      logic [IN_W-1:0] dd [C];
      logic [1:0] gg [C];
      logic [OUT_W-1:0] s, exp_s;
      int lat, vseen;
      logic b;
      for (int k = 0; k < C; k++) begin dd[k] = 14'h2ABC; gg[k] = 2'd3; end
      run_mix(dd, gg, 1'b0, s, lat, b);
      @(negedge clk);
      bus.ce_sample_i = 1'b1;
      @(negedge clk);
      bus.ce_sample_i = 1'b0;
      repeat (2) @(negedge clk);
      res_n = 1'b0;
      #1;
      checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL midreset_busy: got %b expected 0", bus.busy_o); end
      checks++; if (bus.sample_o !== 16'h0000) begin errors++; $display("FAIL midreset_sample: got %h expected 0000", bus.sample_o); end
      checks++; if (bus.overrun_o !== 1'b0) begin errors++; $display("FAIL midreset_overrun: got %b expected 0", bus.overrun_o); end
      vseen = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (i == 2) res_n = 1'b1;
         if (bus.valid_o) vseen++;
      end
      checks++; if (vseen !== 0) begin errors++; $display("FAIL midreset_no_valid: got %0d pulses expected 0", vseen); end
      randomize_ch(dd, gg);
      exp_s = model_mix(dd, gg);
      run_mix(dd, gg, 1'b0, s, lat, b);
      checks++; if (s !== exp_s) begin errors++; $display("FAIL midreset_recover: got %h expected %h", s, exp_s); end
   endtask

   task automatic test_pdm();
      logic [IN_W-1:0] dd [C];
      logic [1:0] gg [C];
      logic [OUT_W-1:0] s;
      int lat, ones;
      logic b;
      for (int k = 0; k < C; k++) begin dd[k] = 14'h2000; gg[k] = 2'd3; end
      run_mix(dd, gg, 1'b0, s, lat, b);
      checks++; if (s !== 16'h8000) begin errors++; $display("FAIL pdm_setup_sample: got %h expected 8000", s); end
      repeat (4) @(negedge clk);
`ifdef AUDIO_MIX_PDM_EN
      ones = 0;
      for (int i = 0; i < 65536; i++) begin
         @(negedge clk);
         if (bus.pdm_o === 1'b1) ones++;
      end
      checks++; if (ones !== 32768) begin errors++; $display("FAIL pdm_half_density: got %0d ones expected 32768", ones); end
`else
      ones = 0;
      for (int i = 0; i < 256; i++) begin
         @(negedge clk);
         if (bus.pdm_o !== 1'b0) ones++;
      end
      checks++; if (ones !== 0) begin errors++; $display("FAIL pdm_tied_low: got %0d non-zero clocks expected 0", ones); end
`endif
      for (int k = 0; k < C; k++) gg[k] = 2'd0;
      run_mix(dd, gg, 1'b0, s, lat, b);
      checks++; if (s !== 16'h0000) begin errors++; $display("FAIL pdm_zero_sample: got %h expected 0000", s); end
      repeat (4) @(negedge clk);
      ones = 0;
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk);
         if (bus.pdm_o !== 1'b0) ones++;
      end
      checks++; if (ones !== 0) begin errors++; $display("FAIL pdm_zero_density: got %0d ones expected 0", ones); end
   endtask

   initial begin
      res_n = 1'b0;
      bus.ce_sample_i = 1'b0;
      bus.ch_data_i = '0;
      bus.ch_gain_i = '0;
      test_reset();
      test_single_channel();
      test_full_scale();
      test_random();
      test_snapshot();
      test_overrun();
      test_reset_mid_mix();
      test_pdm();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

`default_nettype wire
